ram_sp_sweep: RTL

- Parameterised single-port synchronous RAM for the accumulator processor, with a working write port.
- Memory clearing is done by a sequential sweep engine rather than a single-cycle array clear. The sweep is started by reset or by a soft-clear request.
- Outputs report busy, read-valid and rejected-access status so the control unit can sequence fetches and stores.

---
 rtl/ram_sp_sweep.sv | 111 +++++++++++
 1 files changed

// File: rtl/ram_sp_sweep.sv
// Single-port synchronous RAM whose contents are cleared by a one-word-per-cycle sweep.
// The sweep is launched by reset (when CLR_ON_RESET=1) or by the zero soft-clear request.
module ram_sp_sweep #(
    parameter int unsigned D_WIDTH      = 16,
    parameter int unsigned A_WIDTH      = 8,
    parameter logic [15:0] IDLE_VAL     = 16'h0055,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               enab,
    input  logic               rw,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] data_in,
    input  logic               zero,
    output logic [D_WIDTH-1:0] data_out,
    output logic               rd_valid,
    output logic               busy,
    output logic               rejected
);
    localparam int unsigned        DEPTH  = 2**A_WIDTH;
    localparam logic [D_WIDTH-1:0] IDLE_W = D_WIDTH'(IDLE_VAL);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    localparam state_e RST_STATE = CLR_ON_RESET ? S_CLEAR : S_IDLE;

    logic [D_WIDTH-1:0] mem [DEPTH];

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic [D_WIDTH-1:0] dout_q, dout_d;
    logic               rdv_q, rdv_d;
    logic               rej_q, rej_d;

    logic               mem_we;
    logic [A_WIDTH-1:0] mem_wa;
    logic [D_WIDTH-1:0] mem_wd;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            dout_q  <= IDLE_W;
            rdv_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rdv_q   <= rdv_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rdv_d   = 1'b0;
        rej_d   = 1'b0;
        mem_we  = 1'b0;
        mem_wa  = addr;
        mem_wd  = data_in;
        case (state_q)
            S_CLEAR: begin
                // Sweep owns the single port: every user access is dropped.
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                cnt_d  = cnt_q + A_WIDTH'(1);
                dout_d = IDLE_W;
                rej_d  = enab;
                if (&cnt_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (zero) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    dout_d  = IDLE_W;
                    rej_d   = enab;
                end else if (enab && !rw) begin
                    dout_d = mem[addr];
                    rdv_d  = 1'b1;
                end else if (enab) begin
                    mem_we = 1'b1;
                end else begin
                    dout_d = IDLE_W;
                end
            end
        endcase
    end

    // Array carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign data_out = dout_q;
    assign rd_valid = rdv_q;
    assign rejected = rej_q;
    assign busy     = (state_q == S_CLEAR);

endmodule
